// File: rtl/regfile_mp_sb.sv
// Two-write-port integer register file with optional write-to-read bypass,
// a per-register pending scoreboard and a post-reset sequential clear sweep.
module regfile_mp_sb #(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic            we_a,
  input  logic [AW-1:0]   waddr_a,
  input  logic [XLEN-1:0] wdata_a,
  input  logic            we_b,
  input  logic [AW-1:0]   waddr_b,
  input  logic [XLEN-1:0] wdata_b,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  output logic            busy1,
  output logic            busy2,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            waw_hazard
);

  localparam int NREGS = 1 << AW;
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [NREGS-1:0]  pending_q, pending_d;
  logic [XLEN-1:0]   regs [NREGS];

  logic run, wr_a, wr_b;

  // Handshake: ready acts as the accept signal for we_a, we_b and issue_valid;
  // any of them presented while ready=0 is dropped, with no backpressure or retry.
  assign run   = (state_q == RUN);
  assign ready = run;
  assign wr_a  = run && we_a && (waddr_a != '0);
  assign wr_b  = run && we_b && (waddr_b != '0);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    pending_d = pending_q;
    if (rst) begin
      state_d   = CLEAR;
      ptr_d     = AW'(1);
      pending_d = '0;
    end else if (state_q == CLEAR) begin
      if (ptr_q == LAST) state_d = RUN;
      else               ptr_d   = ptr_q + AW'(1);
    end else begin
      if (wr_b) pending_d[waddr_b] = 1'b0;
      // Set after clear: a newly issued op owns the register even if an older result retires now.
      if (issue_valid && (issue_rd != '0)) pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    ptr_q     <= ptr_d;
    pending_q <= pending_d;
  end

  // Contents are left untouched on a reset edge; the sweep clears them afterwards.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == CLEAR) begin
        regs[ptr_q] <= '0;
      end else begin
        if (wr_a) regs[waddr_a] <= wdata_a;
        if (wr_b) regs[waddr_b] <= wdata_b;
      end
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] a);
    logic [XLEN-1:0] d;
    d = '0;
    if (run && (a != '0)) begin
      if ((BYPASS != 0) && wr_b && (waddr_b == a))      d = wdata_b;
      else if ((BYPASS != 0) && wr_a && (waddr_a == a)) d = wdata_a;
      else                                              d = regs[a];
    end
    return d;
  endfunction

  function automatic logic busy_port(input logic [AW-1:0] a);
    return run && (a != '0) && pending_q[a] &&
           !((BYPASS != 0) && we_b && (waddr_b == a));
  endfunction

  always_comb begin
    rdata1     = read_port(raddr1);
    rdata2     = read_port(raddr2);
    busy1      = busy_port(raddr1);
    busy2      = busy_port(raddr2);
    waw_hazard = run && issue_valid && (issue_rd != '0) && pending_q[issue_rd] &&
                 !(we_b && (waddr_b == issue_rd));
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised integer register file; successor to the single-write-port 32x32 file.
- Provides two write ports: port A for the ALU writeback, port B for load / multi-cycle writeback.
- Adds a write-to-read bypass option and a per-register pending scoreboard for in-flight multi-cycle results.
- Clears its contents with a sequential sweep after reset, instead of clearing every register in parallel.
- Sits between decode/issue (read ports, scoreboard) and the writeback stage (write ports).

Parameters:
- XLEN, 32, data width of each register.
- AW, 5, address width; NREGS = 2**AW registers; register 0 is hard-wired zero.
- BYPASS, 1, 1 = a read of a register being written in the same cycle returns the new data; 0 = it returns the old data.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  high once the clear sweep has finished; writes and issues are accepted only while ready=1.
- we_a  in  1  write enable, port A.
- waddr_a  in  AW  write address, port A.
- wdata_a  in  XLEN  write data, port A.
- we_b  in  1  write enable, port B; also retires the pending bit of its address.
- waddr_b  in  AW  write address, port B.
- wdata_b  in  XLEN  write data, port B.
- raddr1  in  AW  read address 1 (rs1).
- raddr2  in  AW  read address 2 (rs2).
- rdata1  out  XLEN  combinational read data 1.
- rdata2  out  XLEN  combinational read data 2.
- busy1  out  1  register raddr1 has a result outstanding.
- busy2  out  1  register raddr2 has a result outstanding.
- issue_valid  in  1  a multi-cycle op is issued this cycle.
- issue_rd  in  AW  destination register of the issued op.
- waw_hazard  out  1  issue_valid and issue_rd is already pending and is not being retired this cycle.

Behaviour:
- Reset: on any posedge with rst=1:
  - state <= CLEAR, ptr <= 1, all pending bits <= 0.
  - Write ports and issue are ignored.
  - Register contents are not modified on that edge.
- Outputs while state=CLEAR: ready=0, rdata1/rdata2=0, busy1/busy2=0, waw_hazard=0.
- CLEAR state, on each posedge with rst=0:
  - reg[ptr] <= 0, ptr <= ptr+1.
  - When ptr==NREGS-1, state <= RUN.
  - ready rises exactly NREGS-1 edges after rst falls (31 edges for AW=5).
- Reset mid-sweep: rst=1 during CLEAR restarts the sweep at ptr=1.
- Reset during RUN: drops ready on the next edge, clears all pending bits and restarts the sweep.
- RUN writes:
  - we_a && waddr_a!=0 → reg[waddr_a] <= wdata_a.
  - we_b && waddr_b!=0 → reg[waddr_b] <= wdata_b.
  - Same nonzero address on both ports in one cycle: port B wins.
  - Writes to address 0 are dropped.
- Reads (RUN), combinational:
  - raddr==0 → 0.
  - BYPASS=1: read address matches an active write this cycle → forwarded wdata, with port B taking priority over port A.
  - Otherwise → the stored value.
- Scoreboard, at each posedge in RUN:
  - issue_valid && issue_rd!=0 → pending[issue_rd] <= 1.
  - we_b && waddr_b!=0 → pending[waddr_b] <= 0.
  - Set and clear of the same register in one cycle: set wins, because a new op now owns the register.
  - Port A writes never touch pending.
  - pending[0] is always 0.
- busyN = pending[raddrN], forced to 0 when raddrN==0 or when (BYPASS=1 && we_b && waddr_b==raddrN).
- waw_hazard = issue_valid && issue_rd!=0 && pending[issue_rd] && !(we_b && waddr_b==issue_rd).
  - Informational only; the register still becomes pending.
- Width rules: no arithmetic on data; ptr is AW bits wide and never wraps, because the sweep stops at NREGS-1.

Test Plan:
- rst high for 2 cycles, then low, AW=5 → ready=0 for exactly 31 edges and 1 on the 32nd; every register then reads 0.
- After ready: we_a=1, waddr_a=3, wdata_a=0x11 together with we_b=1, waddr_b=3, wdata_b=0x22, raddr1=3 →
  - BYPASS=1: rdata1=0x22 in the same cycle.
  - BYPASS=0: rdata1 shows the old value, then 0x22 after the edge.
  - Writes to x0 leave rdata=0.
- issue_valid=1, issue_rd=7; next cycle raddr1=7 → busy1=1. Re-issue rd=7 → waw_hazard=1. we_b=1 with waddr_b=7 → busy1=0 in the same cycle (BYPASS=1) and pending[7] cleared after the edge.
- Same cycle issue_rd=9 and we_b waddr_b=9 with 9 already pending → waw_hazard=0, and pending[9] remains 1 after the edge.
- Assert rst at sweep ptr=15 → sweep restarts and ready rises 31 edges after rst falls. Writes and issues presented during CLEAR have no effect: registers read 0 and busy=0 afterwards.
- Load x5=0xDEADBEEF, then pulse rst for 1 cycle → x5 reads 0 once ready returns, and all busy outputs are 0.
